// File: rtl/watch_alarm_pkg.sv
// Shared constants for the alarm watch: field limits, default widths and
// the alarm state encoding.
package watch_alarm_pkg;

  localparam int DEF_COUNT_BIT = 30;
  localparam int DEF_SEC_BIT   = 6;
  localparam int DEF_MIN_BIT   = 6;
  localparam int DEF_HOUR_BIT  = 5;
  localparam int DEF_RING_SEC  = 30;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef logic [1:0] alarm_state_t;

  localparam alarm_state_t ALM_OFF     = 2'd0;
  localparam alarm_state_t ALM_ARMED   = 2'd1;
  localparam alarm_state_t ALM_RINGING = 2'd2;

  function automatic logic field_ok(input int unsigned value, input int unsigned max_value);
    return value <= max_value;
  endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Clocks-per-second prescaler; raises a combinational tick strobe in the
// cycle the count wraps so the caller can update time on that same edge.
module watch_tick_gen
  import watch_alarm_pkg::*;
#(
  parameter int P_COUNT_BIT = DEF_COUNT_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_clear,
  output logic                   o_tick
);

  logic [P_COUNT_BIT-1:0] count;
  logic [P_COUNT_BIT-1:0] last;

  // A frequency of 0 behaves like 1: every enabled cycle is a tick.
  assign last   = (i_freq == '0) ? '0 : i_freq - 1'b1;
  assign o_tick = i_run_en && (count >= last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (i_clear || o_tick)
      count <= '0;
    else if (i_run_en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/watch_alarm_top.sv
// Time-of-day watch with settable time, one alarm and a bounded ring period.
// Time, tick and alarm outputs all change on the same clock edge.
module watch_alarm_top
  import watch_alarm_pkg::*;
#(
  parameter int P_COUNT_BIT = DEF_COUNT_BIT,
  parameter int P_SEC_BIT   = DEF_SEC_BIT,
  parameter int P_MIN_BIT   = DEF_MIN_BIT,
  parameter int P_HOUR_BIT  = DEF_HOUR_BIT,
  parameter int P_RING_SEC  = DEF_RING_SEC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_load,
  input  logic [P_SEC_BIT-1:0]   i_load_sec,
  input  logic [P_MIN_BIT-1:0]   i_load_min,
  input  logic [P_HOUR_BIT-1:0]  i_load_hour,
  input  logic                   i_alarm_set,
  input  logic [P_MIN_BIT-1:0]   i_alarm_min,
  input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
  input  logic                   i_alarm_en,
  input  logic                   i_alarm_ack,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic                   o_tick,
  output logic                   o_load_err,
  output logic                   o_alarm
);

  localparam int RING_W = (P_RING_SEC < 1) ? 1 : $clog2(P_RING_SEC + 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(P_RING_SEC - 1);

  logic                  tick_raw;
  logic                  tick_eff;
  logic                  load_range;
  logic                  load_ok;
  logic                  aset_range;
  logic                  aset_ok;
  logic                  match;
  logic [P_SEC_BIT-1:0]  nxt_sec;
  logic [P_MIN_BIT-1:0]  nxt_min;
  logic [P_HOUR_BIT-1:0] nxt_hour;
  logic [P_MIN_BIT-1:0]  alarm_min;
  logic [P_HOUR_BIT-1:0] alarm_hour;
  alarm_state_t          state;
  logic [RING_W-1:0]     ring_cnt;

  assign load_range = field_ok(32'(i_load_sec), SEC_MAX) &&
                      field_ok(32'(i_load_min), MIN_MAX) &&
                      field_ok(32'(i_load_hour), HOUR_MAX);
  assign aset_range = field_ok(32'(i_alarm_min), MIN_MAX) &&
                      field_ok(32'(i_alarm_hour), HOUR_MAX);
  assign load_ok    = i_load && load_range;
  assign aset_ok    = i_alarm_set && aset_range;

  // A valid load wins over a same-cycle tick; the tick is simply lost.
  assign tick_eff   = tick_raw && !load_ok;

  watch_tick_gen #(
    .P_COUNT_BIT(P_COUNT_BIT)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .i_run_en (i_run_en),
    .i_freq   (i_freq),
    .i_clear  (load_ok),
    .o_tick   (tick_raw)
  );

  always_comb begin
    nxt_sec  = o_sec;
    nxt_min  = o_min;
    nxt_hour = o_hour;
    if (load_ok) begin
      nxt_sec  = i_load_sec;
      nxt_min  = i_load_min;
      nxt_hour = i_load_hour;
    end else if (tick_eff) begin
      if (o_sec == P_SEC_BIT'(SEC_MAX)) begin
        nxt_sec = '0;
        if (o_min == P_MIN_BIT'(MIN_MAX)) begin
          nxt_min  = '0;
          nxt_hour = (o_hour == P_HOUR_BIT'(HOUR_MAX)) ? '0 : o_hour + 1'b1;
        end else begin
          nxt_min = o_min + 1'b1;
        end
      end else begin
        nxt_sec = o_sec + 1'b1;
      end
    end
  end

  // Only a change of time (tick or load) landing exactly on hh:mm:00 can ring.
  assign match = (load_ok || tick_eff) && (nxt_sec == '0) &&
                 (nxt_min == alarm_min) && (nxt_hour == alarm_hour);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_sec      <= '0;
      o_min      <= '0;
      o_hour     <= '0;
      o_tick     <= 1'b0;
      o_load_err <= 1'b0;
      alarm_min  <= '0;
      alarm_hour <= '0;
    end else begin
      o_sec      <= nxt_sec;
      o_min      <= nxt_min;
      o_hour     <= nxt_hour;
      o_tick     <= tick_eff;
      o_load_err <= (i_load && !load_range) || (i_alarm_set && !aset_range);
      if (aset_ok) begin
        alarm_min  <= i_alarm_min;
        alarm_hour <= i_alarm_hour;
      end
    end
  end

  // Ring timeout counts effective ticks only, so a stopped clock freezes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ALM_OFF;
      ring_cnt <= '0;
    end else if (!i_alarm_en) begin
      state    <= ALM_OFF;
      ring_cnt <= '0;
    end else begin
      case (state)
        ALM_OFF: state <= ALM_ARMED;
        ALM_ARMED: begin
          if (match) begin
            state    <= ALM_RINGING;
            ring_cnt <= '0;
          end
        end
        ALM_RINGING: begin
          if (i_alarm_ack) begin
            state <= ALM_ARMED;
          end else if (tick_eff) begin
            if (ring_cnt == RING_LAST)
              state <= ALM_ARMED;
            else
              ring_cnt <= ring_cnt + 1'b1;
          end
        end
        default: state <= ALM_OFF;
      endcase
    end
  end

  assign o_alarm = (state == ALM_RINGING);

endmodule
